muldiv_seq: RTL

Iterative RV32M multiply/divide sequencer for the Execute stage, alongside the single-cycle ALU. It accepts an M-extension operation with the Execute-stage operands and runs a 32-step shift-add (multiply) or restoring-division loop. While it runs, it holds the pipeline through a stall output, then presents a one-cycle result for the Execute-stage result mux.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_signfix.sv | 53 +++++
 rtl/muldiv_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 op
// encodings, the sequencer state type and the iteration count.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam int MD_ITER = 32;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdState_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling for the multiply/divide sequencer. Converts the incoming
// operands to magnitudes according to the op's signedness, works out the sign
// the final result must carry, and applies the two's-complement fixup to the
// raw 64-bit result when the sequencer presents it.
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic [31:0] magA,
  output logic [31:0] magB,
  output logic        resultNeg,
  input  logic [63:0] rawResult,
  input  logic        negate,
  output logic [63:0] fixedResult
);

  logic signedA;
  logic signedB;
  logic signA;
  logic signB;

  // Operand magnitudes and result sign; MUL is run unsigned since its low word does not depend on signedness
  always_comb begin
    signedA   = 1'b0;
    signedB   = 1'b0;
    resultNeg = 1'b0;
    case (op)
      MD_MULH, MD_DIV, MD_REM: begin
        signedA = 1'b1;
        signedB = 1'b1;
      end
      MD_MULHSU: signedA = 1'b1;
      default: ;
    endcase
    signA = signedA & srcA[31];
    signB = signedB & srcB[31];
    magA  = signA ? (~srcA + 32'd1) : srcA;
    magB  = signB ? (~srcB + 32'd1) : srcB;
    case (op)
      MD_MULH, MD_DIV:   resultNeg = signA ^ signB;
      MD_MULHSU, MD_REM: resultNeg = signA;
      default:           resultNeg = 1'b0;
    endcase
  end

  // Negate the full 64-bit raw result so the high product word gets the borrow from the low word
  always_comb begin
    fixedResult = negate ? (~rawResult + 64'd1) : rawResult;
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the Execute stage.
// Multiply is a 32-step shift-add on a 64-bit product register; divide is a
// 32-step restoring division on a remainder:quotient register pair. Divide by
// zero and signed overflow skip the loop and finish the cycle after issue.
// Build option: define MULDIV_DIV_EN to include the divider. Without it, all
// divide/remainder ops finish the cycle after issue with a zero result.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StartE,
  input  logic [2:0]  MulDivOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  output logic        StallE,
  output logic        DoneE,
  output logic [31:0] MulDivResultE
);

  mdState_e         state;
  mdState_e         nextState;
  logic [CNT_W-1:0] counter;
  logic [2:0]       opReg;
  logic [31:0]      accHi;
  logic [31:0]      accLo;
  logic [31:0]      operandB;
  logic             negReg;

  logic [31:0]      magA;
  logic [31:0]      magB;
  logic             resultNeg;
  logic [63:0]      rawResult;
  logic [63:0]      fixedResult;

  logic             startAccept;
  logic             fastPath;
  logic [31:0]      fastHi;
  logic [31:0]      fastLo;
  logic [32:0]      mulSum;
  logic [63:0]      mulNext;
`ifdef MULDIV_DIV_EN
  logic             divByZero;
  logic             divOverflow;
  logic [32:0]      divShifted;
  logic             divBorrow;
  logic [63:0]      divNext;
`endif

  assign startAccept = (state == IDLE) && StartE && !FlushE;
  assign StallE      = startAccept || (state == CALC);

  muldiv_signfix signFix (
    .op          (MulDivOpE),
    .srcA        (SrcAE),
    .srcB        (SrcBE),
    .magA        (magA),
    .magB        (magB),
    .resultNeg   (resultNeg),
    .rawResult   (rawResult),
    .negate      (negReg),
    .fixedResult (fixedResult)
  );

`ifdef MULDIV_DIV_EN
  // Detect divide special cases at issue; their results are loaded as {remainder, quotient}
  always_comb begin
    divByZero   = (SrcBE == 32'd0);
    divOverflow = ((MulDivOpE == MD_DIV) || (MulDivOpE == MD_REM)) &&
                  (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);
    fastPath    = MulDivOpE[2] && (divByZero || divOverflow);
    fastHi      = divByZero ? SrcAE : 32'd0;
    fastLo      = divByZero ? 32'hFFFF_FFFF : 32'h8000_0000;
  end
`else
  // Without the divider every divide/remainder op completes immediately with zero
  always_comb begin
    fastPath = MulDivOpE[2];
    fastHi   = 32'd0;
    fastLo   = 32'd0;
  end
`endif

  // One shift-add multiply step: add multiplicand into the high half when the low bit is set, then shift right
  always_comb begin
    mulSum  = {1'b0, accHi} + (accLo[0] ? {1'b0, operandB} : 33'd0);
    mulNext = {mulSum, accLo[31:1]};
  end

`ifdef MULDIV_DIV_EN
  // One restoring-division step: shift remainder:quotient left, keep the trial difference when it does not borrow
  always_comb begin
    divShifted = {accHi, accLo[31]};
    divBorrow  = divShifted < {1'b0, operandB};
    divNext    = {divBorrow ? divShifted[31:0] : (divShifted[31:0] - operandB),
                  accLo[30:0], ~divBorrow};
  end
`endif

  // Next-state logic; a flush wins over everything and returns to IDLE
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (startAccept) nextState = fastPath ? DONE : CALC;
      CALC: if (counter == CNT_W'(MD_ITER - 1)) nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (FlushE) nextState = IDLE;
  end

  // Result presentation: pick product word, quotient or remainder and drive it only while DONE
  always_comb begin
    DoneE         = 1'b0;
    MulDivResultE = 32'd0;
    if (!opReg[2])     rawResult = {accHi, accLo};
    else if (opReg[1]) rawResult = {32'd0, accHi};
    else               rawResult = {32'd0, accLo};
    if ((state == DONE) && !FlushE) begin
      DoneE         = 1'b1;
      MulDivResultE = (!opReg[2] && (opReg[1:0] != 2'b00)) ? fixedResult[63:32]
                                                           : fixedResult[31:0];
    end
  end

  // State register plus operand latch and iteration datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      counter  <= '0;
      opReg    <= '0;
      accHi    <= '0;
      accLo    <= '0;
      operandB <= '0;
      negReg   <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (startAccept) begin
            opReg    <= MulDivOpE;
            counter  <= '0;
            operandB <= magB;
            if (fastPath) begin
              accHi  <= fastHi;
              accLo  <= fastLo;
              negReg <= 1'b0;
            end else begin
              accHi  <= '0;
              accLo  <= magA;
              negReg <= resultNeg;
            end
          end
        end
        CALC: begin
          counter <= counter + CNT_W'(1);
`ifdef MULDIV_DIV_EN
          if (opReg[2]) {accHi, accLo} <= divNext;
          else          {accHi, accLo} <= mulNext;
`else
          {accHi, accLo} <= mulNext;
`endif
        end
        default: ;
      endcase
      if (nextState == IDLE) counter <= '0;
    end
  end

endmodule
